// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: counter width and parameter legality check.
package fifo_pkg;

  // Width needed to hold an occupancy of 0..depth inclusive.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Depth must be a power of two >= 2 and 0 <= ae_th < af_th <= depth.
  function automatic bit fifo_params_ok(input int depth, input int af_th, input int ae_th);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (ae_th >= 0) && (ae_th < af_th) && (af_th <= depth);
  endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read
// port, whole array cleared on reset so the read port is deterministic.
module stream_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;

  // Write port; reset clears every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem <= '0;
    else if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through valid/ready FIFO using all DEPTH entries.
// Full/empty come from the occupancy counter, so no pointer-equality
// ambiguity; every output depends only on registered state.
module stream_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AF_TH = 14,
  parameter int AE_TH = 2,
  localparam int CW = fifo_cnt_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [CW-1:0]    count_o,
  output logic             almost_full_o,
  output logic             almost_empty_o
);

  localparam int AW = $clog2(DEPTH);

  if (!fifo_params_ok(DEPTH, AF_TH, AE_TH)) begin : g_bad_params
    $error("stream_fifo: illegal DEPTH/AF_TH/AE_TH combination");
  end

  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;
  logic          push, pop;

  // Ready/valid derive from count alone: no out_ready -> in_ready pass-through
  // and no in_data -> out_data bypass when empty.
  assign in_ready_o     = (count < CW'(DEPTH));
  assign out_valid_o    = (count != '0);
  assign count_o        = count;
  assign almost_full_o  = (count >= CW'(AF_TH));
  assign almost_empty_o = (count <= CW'(AE_TH));

  assign push = in_valid_i & in_ready_o;
  assign pop  = out_valid_o & out_ready_i;

  // Pointer and occupancy update; flush wins over any same-cycle transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // A push coinciding with flush is dropped, so it must not touch memory.
  stream_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .wr_en   (push & ~flush_i),
    .wr_addr (tail),
    .wr_data (in_data_i),
    .rd_addr (head),
    .rd_data (out_data_o)
  );

endmodule
